// File: rtl/dpram_be_clr_pkg.sv
// Shared types and helpers for the dual-port RAM with byte enables and clear sequencer.
//   clr_state_e : clear sequencer states (StClear, StIdle)
//   bytes_of()  : byte-lane count of a word width
//   be_merge()  : overlay new bytes onto an old word under byte enables
package dpram_be_clr_pkg;

   typedef enum logic [0:0] {StClear, StIdle} clr_state_e;

   // be_merge works on a fixed maximum width; callers zero-extend and truncate.
   localparam int unsigned MaxDataW = 256;
   localparam int unsigned MaxBeW   = MaxDataW / 8;

   function automatic int unsigned bytes_of(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic logic [MaxDataW-1:0] be_merge(input logic [MaxDataW-1:0] old_w,
                                                    input logic [MaxDataW-1:0] new_w,
                                                    input logic [MaxBeW-1:0]   be);
      logic [MaxDataW-1:0] r;
      r = old_w;
      for (int i = 0; i < int'(MaxBeW); i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// Bus bundle for dpram_be_clr.
//   Port A (read-only): addr, ce_n, oe_n -> dout
//   Port B (read/write): we, waddr, wdata, wbe -> doutb
//   Clear control: clr_req -> busy
//   master: the user of the RAM; slave: the RAM itself.
interface dpram_be_clr_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] addr;
   logic              ce_n;
   logic              oe_n;
   logic [DATA_W-1:0] dout;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [BE_W-1:0]   wbe;
   logic [DATA_W-1:0] doutb;
   logic              clr_req;
   logic              busy;

   modport master (
      output addr, ce_n, oe_n, we, waddr, wdata, wbe, clr_req,
      input  dout, doutb, busy
   );

   modport slave (
      input  addr, ce_n, oe_n, we, waddr, wdata, wbe, clr_req,
      output dout, doutb, busy
   );

endinterface

// File: rtl/dpram_clr_seq.sv
// Clear sequencer: walks every address once writing the fill value, after reset or on request.
//   clk, rst_n : clock, async active-low reset (reset starts a clear)
//   clr_req    : request a full clear (ignored while clearing)
//   busy       : high while clearing
//   clr_we     : clear write strobe for the current address
//   clr_addr   : address being cleared
module dpram_clr_seq
   import dpram_be_clr_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   // One extra counter bit so the last address is unambiguous.
   localparam logic [ADDR_W:0] LastAddr = {1'b0, {ADDR_W{1'b1}}};

   clr_state_e      state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + (ADDR_W+1)'(1);
            if (cnt_q == LastAddr) state_d = StIdle;
         end
         StIdle: begin
            if (clr_req) begin
               cnt_d   = '0;
               state_d = StClear;
            end
         end
      endcase
   end

   assign busy     = (state_q == StClear);
   assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/dpram_be_clr.sv
// Dual-port RAM: port A registered read with ce_n/oe_n output gating, port B read/write
// with byte enables and selectable read-during-write, optional output register on both
// ports, and a clear sequencer that fills the array with CLR_VAL.
//   clk, rst_n : clock, async active-low reset
//   bus        : dpram_be_clr_if slave (port A, port B, clr_req/busy)
module dpram_be_clr
   import dpram_be_clr_pkg::*;
#(
   parameter int unsigned       ADDR_W  = 10,
   parameter int unsigned       DATA_W  = 8,
   parameter logic [DATA_W-1:0] CLR_VAL = '0,
   parameter bit                RDW_NEW = 1'b0,
   parameter bit                OUT_REG = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   dpram_be_clr_if.slave bus
);

   localparam int unsigned BE_W  = bytes_of(DATA_W);
   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [Depth];

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   dpram_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (bus.clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Port B is borrowed by the sequencer while clearing; user writes are dropped.
   logic              wr_en;
   logic [ADDR_W-1:0] b_addr;
   logic [BE_W-1:0]   b_be;
   logic [DATA_W-1:0] b_wdata;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged;

   always_comb begin
      wr_en   = bus.we;
      b_addr  = bus.waddr;
      b_be    = bus.wbe;
      b_wdata = bus.wdata;
      if (busy) begin
         wr_en   = clr_we;
         b_addr  = clr_addr;
         b_be    = '1;
         b_wdata = CLR_VAL;
      end
   end

   assign old_word = mem[b_addr];
   assign merged   = DATA_W'(be_merge(MaxDataW'(old_word), MaxDataW'(b_wdata), MaxBeW'(b_be)));

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < int'(BE_W); i++) begin
            if (b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
         end
      end
   end

   // Port A always sees the pre-write word on a same-address collision.
   logic [DATA_W-1:0] a_q, b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= mem[bus.addr];
         b_q <= (RDW_NEW && wr_en) ? merged : old_word;
      end
   end

   logic [DATA_W-1:0] a_fin, b_fin;

   if (OUT_REG) begin : g_out_reg
      logic [DATA_W-1:0] a2_q, b2_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a2_q <= '0;
            b2_q <= '0;
         end else begin
            a2_q <= a_q;
            b2_q <= b_q;
         end
      end
      assign a_fin = a2_q;
      assign b_fin = b2_q;
   end else begin : g_no_out_reg
      assign a_fin = a_q;
      assign b_fin = b_q;
   end

   // Gating is on the final stage so ce_n/oe_n/busy act in the same cycle.
   assign bus.dout  = (!bus.ce_n && !bus.oe_n && !busy) ? a_fin : '0;
   assign bus.doutb = busy ? '0 : b_fin;
   assign bus.busy  = busy;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances driven by the same stimulus,
// u_dut0 (RDW_NEW=0, OUT_REG=0) and u_dut1 (RDW_NEW=1, OUT_REG=1), ADDR_W=4, DATA_W=16.
module tb_dpram_be_clr;

   localparam logic [15:0] ClrVal = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  addr = '0;
   logic [3:0]  waddr = '0;
   logic        ce_n = 1'b1;
   logic        oe_n = 1'b1;
   logic        we = 1'b0;
   logic        clr_req = 1'b0;
   logic [15:0] wdata = '0;
   logic [1:0]  wbe = '0;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dpram_be_clr_if #(.ADDR_W(4), .DATA_W(16)) bus0 ();
   dpram_be_clr_if #(.ADDR_W(4), .DATA_W(16)) bus1 ();

   assign bus0.addr = addr;   assign bus1.addr = addr;
   assign bus0.ce_n = ce_n;   assign bus1.ce_n = ce_n;
   assign bus0.oe_n = oe_n;   assign bus1.oe_n = oe_n;
   assign bus0.we = we;       assign bus1.we = we;
   assign bus0.waddr = waddr; assign bus1.waddr = waddr;
   assign bus0.wdata = wdata; assign bus1.wdata = wdata;
   assign bus0.wbe = wbe;     assign bus1.wbe = wbe;
   assign bus0.clr_req = clr_req;
   assign bus1.clr_req = clr_req;

   dpram_be_clr #(
      .ADDR_W (4), .DATA_W (16), .CLR_VAL (ClrVal), .RDW_NEW (1'b0), .OUT_REG (1'b0)
   ) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   dpram_be_clr #(
      .ADDR_W (4), .DATA_W (16), .CLR_VAL (ClrVal), .RDW_NEW (1'b1), .OUT_REG (1'b1)
   ) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: port 0/1 = dut0 dout/doutb, port 2/3 = dut1 dout/doutb.
   typedef struct {
      string       name;
      int unsigned due;
      int unsigned port;
      logic [15:0] exp;
   } sb_t;

   sb_t sb_q[$];
   sb_t sb_keep[$];

   function automatic logic [15:0] port_val(input int unsigned p);
      case (p)
         0:       return bus0.dout;
         1:       return bus0.doutb;
         2:       return bus1.dout;
         default: return bus1.doutb;
      endcase
   endfunction

   task automatic push_exp(input string name, input int unsigned due, input int unsigned port,
                           input logic [15:0] exp);
      sb_t e;
      e.name = $sformatf("%s_p%0d", name, port);
      e.due  = due;
      e.port = port;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      sb_keep = {};
      for (int i = 0; i < sb_q.size(); i++) begin
         if (sb_q[i].due == cyc) check(sb_q[i].name, 32'(port_val(sb_q[i].port)), 32'(sb_q[i].exp));
         else if (sb_q[i].due < cyc) check({sb_q[i].name, "_overdue"}, 32'(cyc), 32'(sb_q[i].due));
         else sb_keep.push_back(sb_q[i]);
      end
      sb_q = sb_keep;
   end

   // Read both ports at one address; dut1 has one extra cycle of latency.
   task automatic issue_read(input string name, input logic [3:0] a, input logic [15:0] exp);
      addr  = a;
      waddr = a;
      we    = 1'b0;
      push_exp(name, cyc + 1, 0, exp);
      push_exp(name, cyc + 1, 1, exp);
      push_exp(name, cyc + 2, 2, exp);
      push_exp(name, cyc + 2, 3, exp);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      wbe   = be;
      @(negedge clk);
      we    = 1'b0;
      wbe   = '0;
   endtask

   // Counts busy cycles from the current negedge; optional clr_req pulse at iteration pulse_at.
   task automatic count_busy(input string name, input int pulse_at);
      int unsigned n0, n1;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 100 && (bus0.busy || bus1.busy); k++) begin
         if (bus0.busy) n0++;
         if (bus1.busy) n1++;
         clr_req = (k == pulse_at);
         if (k == 3) begin
            check({name, "_mask_dout0"}, 32'(bus0.dout), 32'h0);
            check({name, "_mask_doutb1"}, 32'(bus1.doutb), 32'h0);
         end
         @(negedge clk);
      end
      clr_req = 1'b0;
      check({name, "_busy_len0"}, n0, 32'd16);
      check({name, "_busy_len1"}, n1, 32'd16);
   endtask

   typedef struct {
      logic        is_wr;
      logic [3:0]  a;
      logic [15:0] d;
      logic [1:0]  be;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 4'd3,  16'h1234, 2'b11, 16'h0000};
      vecs[1]  = '{1'b1, 4'd3,  16'hABCD, 2'b01, 16'h0000};
      vecs[2]  = '{1'b0, 4'd3,  16'h0000, 2'b00, 16'h12CD};
      vecs[3]  = '{1'b1, 4'd5,  16'h0011, 2'b11, 16'h0000};
      vecs[4]  = '{1'b1, 4'd9,  16'hFFFF, 2'b10, 16'h0000};
      vecs[5]  = '{1'b0, 4'd9,  16'h0000, 2'b00, 16'hFFA5};
      vecs[6]  = '{1'b1, 4'd0,  16'hBEEF, 2'b00, 16'h0000};
      vecs[7]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 16'hA5A5};
      vecs[8]  = '{1'b0, 4'd5,  16'h0000, 2'b00, 16'h0011};
      vecs[9]  = '{1'b1, 4'd12, 16'h00C3, 2'b01, 16'h0000};
      vecs[10] = '{1'b0, 4'd12, 16'h0000, 2'b00, 16'hA5C3};

      // Reset state.
      ce_n = 1'b0;
      oe_n = 1'b0;
      @(negedge clk);
      check("rst_busy0", 32'(bus0.busy), 32'h1);
      check("rst_busy1", 32'(bus1.busy), 32'h1);
      check("rst_dout0", 32'(bus0.dout), 32'h0);
      check("rst_doutb0", 32'(bus0.doutb), 32'h0);
      check("rst_doutb1", 32'(bus1.doutb), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy("init", -1);

      for (int i = 0; i < 16; i++) issue_read($sformatf("init_rd%0d", i), 4'(i), ClrVal);

      // Table-driven writes and reads.
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].d, vecs[i].be);
         else issue_read($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
      end

      // Read-during-write on port B at address 5 (old 0x0011), with port A colliding.
      we    = 1'b1;
      waddr = 4'd5;
      addr  = 4'd5;
      wdata = 16'h0022;
      wbe   = 2'b11;
      push_exp("rdw", cyc + 1, 0, 16'h0011);
      push_exp("rdw", cyc + 1, 1, 16'h0011);
      push_exp("rdw", cyc + 2, 2, 16'h0011);
      push_exp("rdw", cyc + 2, 3, 16'h0022);
      @(negedge clk);
      we  = 1'b0;
      wbe = '0;
      issue_read("rdw_after", 4'd5, 16'h0022);
      repeat (3) @(negedge clk);

      // Output gating acts in the same cycle; OUT_REG adds one cycle of latency.
      addr = 4'd3;
      oe_n = 1'b1;
      repeat (3) @(negedge clk);
      check("gate_oe_dout0", 32'(bus0.dout), 32'h0);
      check("gate_oe_dout1", 32'(bus1.dout), 32'h0);
      oe_n = 1'b0;
      #1;
      check("gate_open_dout0", 32'(bus0.dout), 32'h12CD);
      check("gate_open_dout1", 32'(bus1.dout), 32'h12CD);
      ce_n = 1'b1;
      #1;
      check("gate_ce_dout0", 32'(bus0.dout), 32'h0);
      ce_n = 1'b0;
      @(negedge clk);
      addr = 4'd9;
      @(negedge clk);
      check("lat1_dout0", 32'(bus0.dout), 32'hFFA5);
      check("lat1_dout1", 32'(bus1.dout), 32'h12CD);
      @(negedge clk);
      check("lat2_dout1", 32'(bus1.dout), 32'hFFA5);

      // Requested clear from idle, with writes attempted throughout and a repeat request.
      do_write(4'd7, 16'h0055, 2'b11);
      issue_read("pre_clr", 4'd7, 16'h0055);
      repeat (2) @(negedge clk);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      we    = 1'b1;
      waddr = 4'd2;
      wdata = 16'h0077;
      wbe   = 2'b11;
      count_busy("req", 6);
      we  = 1'b0;
      wbe = '0;
      issue_read("req_rd7", 4'd7, ClrVal);
      issue_read("req_rd2", 4'd2, ClrVal);
      issue_read("req_rd3", 4'd3, ClrVal);
      repeat (3) @(negedge clk);

      // Reset pulse during a clear restarts the sequence.
      do_write(4'd14, 16'h1111, 2'b11);
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy0", 32'(bus0.busy), 32'h1);
      check("midrst_doutb1", 32'(bus1.doutb), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy("midrst", -1);
      for (int i = 0; i < 16; i++) issue_read($sformatf("midrst_rd%0d", i), 4'(i), ClrVal);

      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
